jtframe_sdram_arb: RTL and testbench
====================================

// Module: jtframe_sdram_arb
// PURPOSE
//   Round-robin arbiter sharing the single game-side SDRAM read port (sdram_req/ack/addr/bank,
//   data_read/data_rdy) among SLOTS ROM requesters (CPU, char, obj, sound...).
//   Sits between the game core's ROM slots and the board SDRAM controller, in the clk_rom domain.
//   Sequences one outstanding read at a time, returns data to the winning slot and recovers from lost acks.
// PARAMETERS
//   SLOTS   4   number of requesters, 2..8
//   AW      22  SDRAM word-address width
//   TOUT_W  8   width of watchdog counter; timeout = 2**TOUT_W-1 cycles
// PORTS
//   clk_rom      in   1          SDRAM clock; the only clock
//   rst          in   1          synchronous reset, active high
//   downloading  in   1          ROM download in progress; blocks new grants
//   slot_req     in   SLOTS      level request per slot; held until slot_ok/slot_err
//   slot_addr    in   SLOTS*AW   packed addresses, slot i at [i*AW +: AW]
//   slot_bank    in   SLOTS*2    packed banks, slot i at [i*2 +: 2]
//   slot_ok      out  SLOTS      one-cycle data-valid pulse, one-hot
//   slot_err     out  SLOTS      one-cycle timeout pulse, one-hot
//   slot_dout    out  32         read data; valid while slot_ok pulses, held until next completion
//   sdram_req    out  1          request to SDRAM controller, level
//   sdram_addr   out  AW         address of granted slot
//   sdram_bank   out  2          bank of granted slot
//   sdram_ack    in   1          controller accepted request (one-cycle pulse)
//   data_rdy     in   1          read data valid (one-cycle pulse)
//   data_read    in   32         read data from controller
//   busy         out  1          high whenever state != IDLE
// BEHAVIOUR
//   Reset: state=IDLE, sdram_req=0, sdram_addr=0, sdram_bank=0, slot_ok=0, slot_err=0, slot_dout=0,
//     busy=0, last-grant pointer=SLOTS-1 (slot 0 wins first), watchdog=0.
//   States: IDLE -> WAIT_ACK -> WAIT_RDY -> IDLE.
//   IDLE: if !downloading and |slot_req: sel = first requesting slot searching upward from last+1 (mod SLOTS);
//     register sdram_addr/bank from sel, sdram_req<=1, go WAIT_ACK. slot_req at cycle n -> sdram_req at n+1.
//   WAIT_ACK: sdram_req, sdram_addr, sdram_bank held stable. On sdram_ack: sdram_req<=0, go WAIT_RDY.
//     sdram_ack and data_rdy in the same cycle: treated as completion (WAIT_RDY rule applied directly).
//   WAIT_RDY: on data_rdy: slot_dout<=data_read, slot_ok[sel]<=1 for exactly one cycle, last<=sel, go IDLE.
//   Round trip: completion data visible one cycle after data_rdy; the next grant is evaluated in the
//     cycle slot_ok is high, so sdram_req rises again at earliest the cycle after slot_ok.
//   Fairness: a slot that just completed has lowest priority; a continuously requesting slot waits at
//     most SLOTS-1 transactions.
//   Watchdog: cleared on entering WAIT_ACK and WAIT_RDY, increments each cycle in those states.
//     At all-ones: sdram_req<=0, slot_err[sel]<=1 for one cycle, slot_ok stays 0, last<=sel, go IDLE.
//     sdram_ack/data_rdy arriving in IDLE are ignored.
//   slot_req of the granted slot dropping mid-transaction does not abort; completion still pulses slot_ok.
//   downloading rising mid-transaction: the transaction completes normally; no new grant while high.
//   Slots with slot_req=0 are never granted; all-zero slot_req keeps IDLE with sdram_req=0.
//   rst asserted in any state: next cycle all outputs at reset values, in-flight transaction dropped silently.
// TESTING
//   1 Single: slot_req=4'b0100, addr2=22'h12345, bank2=1; ack at +3, rdy at +6, data=32'hDEADBEEF
//     -> sdram_addr=22'h12345, sdram_bank=1, slot_ok=4'b0100 one cycle, slot_dout=32'hDEADBEEF.
//   2 Round-robin: slot_req=4'b1111 held, controller acks/rdys every request
//     -> grant order 0,1,2,3,0,1; never the same slot twice in a row.
//   3 Ack+rdy same cycle: sdram_ack=data_rdy=1 while in WAIT_ACK
//     -> slot_ok pulses next cycle, state IDLE, sdram_req=0.
//   4 Timeout, TOUT_W=4: slot 1 granted, no sdram_ack -> after 15 cycles in WAIT_ACK
//     slot_err=4'b0010, slot_ok=0, sdram_req=0; slot 2 request then served normally.
//   5 Download gating: downloading=1 with slot_req=4'b0011 -> sdram_req stays 0;
//     downloading=0 -> slot 0 granted next cycle.
//   6 Reset mid-op: rst=1 in WAIT_RDY, then data_rdy -> no slot_ok, all outputs 0, next grant is slot 0.

Source files
------------

// File: rtl/jtframe_sdram_arb.sv
// Round-robin arbiter sharing one SDRAM read port among SLOTS ROM requesters.
// One read is outstanding at a time; a watchdog recovers from lost acks or data.
//
// state      | meaning
// S_IDLE     | no transaction; pick next requester round-robin
// S_WAIT_ACK | sdram_req held high, waiting for controller accept
// S_WAIT_RDY | request accepted, waiting for read data
module jtframe_sdram_arb #(
  parameter int SLOTS  = 4,
  parameter int AW     = 22,
  parameter int TOUT_W = 8
) (
  input  logic                i_clk_rom,
  input  logic                i_rst,
  input  logic                i_downloading,
  input  logic [SLOTS-1:0]    i_slot_req,
  input  logic [SLOTS*AW-1:0] i_slot_addr,
  input  logic [SLOTS*2-1:0]  i_slot_bank,
  output logic [SLOTS-1:0]    o_slot_ok,
  output logic [SLOTS-1:0]    o_slot_err,
  output logic [31:0]         o_slot_dout,
  output logic                o_sdram_req,
  output logic [AW-1:0]       o_sdram_addr,
  output logic [1:0]          o_sdram_bank,
  input  logic                i_sdram_ack,
  input  logic                i_data_rdy,
  input  logic [31:0]         i_data_read,
  output logic                o_busy
);

  localparam int SW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT_ACK, S_WAIT_RDY} state_t;

  state_t              r_state, w_state_nxt;
  logic [SW-1:0]       r_sel, r_last, w_sel, w_idx;
  logic                w_found, w_grant, w_accept, w_done, w_tmo, w_tout;
  logic [TOUT_W-1:0]   r_wd, w_wd_inc;
  logic [AW-1:0]       r_addr;
  logic [1:0]          r_bank;
  logic                r_req;
  logic [31:0]         r_dout;
  logic [SLOTS-1:0]    r_slot_ok, r_slot_err, w_sel_oh;
  logic [AW-1:0]       w_addr_arr [SLOTS];
  logic [1:0]          w_bank_arr [SLOTS];

  for (genvar g = 0; g < SLOTS; g++) begin : g_unpack
    assign w_addr_arr[g] = i_slot_addr[g*AW +: AW];
    assign w_bank_arr[g] = i_slot_bank[g*2 +: 2];
  end

  // Search starts just above the last winner, so it has the lowest priority.
  always_comb begin
    w_found = 1'b0;
    w_sel   = r_last;
    w_idx   = r_last;
    for (int k = 1; k <= SLOTS; k++) begin
      w_idx = SW'((int'(r_last) + k) % SLOTS);
      if (!w_found && i_slot_req[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
    end
  end

  assign w_wd_inc = r_wd + 1'b1;
  assign w_tout   = &w_wd_inc;
  assign w_sel_oh = SLOTS'(1) << r_sel;

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_accept    = 1'b0;
    w_done      = 1'b0;
    w_tmo       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!i_downloading && w_found) begin
          w_grant     = 1'b1;
          w_state_nxt = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        if (i_sdram_ack && i_data_rdy) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (i_sdram_ack) begin
          w_accept    = 1'b1;
          w_state_nxt = S_WAIT_RDY;
        end else if (w_tout) begin
          w_tmo       = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT_RDY: begin
        if (i_data_rdy) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_tout) begin
          w_tmo       = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk_rom) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_sel      <= '0;
      r_last     <= SW'(SLOTS - 1);
      r_wd       <= '0;
      r_addr     <= '0;
      r_bank     <= '0;
      r_req      <= 1'b0;
      r_dout     <= '0;
      r_slot_ok  <= '0;
      r_slot_err <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_slot_ok  <= '0;
      r_slot_err <= '0;
      if (w_grant || w_accept) r_wd <= '0;
      else if (r_state != S_IDLE) r_wd <= w_wd_inc;
      if (w_grant) begin
        r_sel  <= w_sel;
        r_addr <= w_addr_arr[w_sel];
        r_bank <= w_bank_arr[w_sel];
        r_req  <= 1'b1;
      end
      if (w_accept) r_req <= 1'b0;
      if (w_done) begin
        r_dout    <= i_data_read;
        r_slot_ok <= w_sel_oh;
        r_last    <= r_sel;
        r_req     <= 1'b0;
      end
      if (w_tmo) begin
        r_slot_err <= w_sel_oh;
        r_last     <= r_sel;
        r_req      <= 1'b0;
      end
    end
  end

  assign o_slot_ok    = r_slot_ok;
  assign o_slot_err   = r_slot_err;
  assign o_slot_dout  = r_dout;
  assign o_sdram_req  = r_req;
  assign o_sdram_addr = r_addr;
  assign o_sdram_bank = r_bank;
  assign o_busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_jtframe_sdram_arb.sv
// Bench for jtframe_sdram_arb: transaction-level reference model compared every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_jtframe_sdram_arb;
  localparam int S     = 4;
  localparam int AW    = 22;
  localparam int TW    = 4;
  localparam int LIMIT = 2**TW - 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            dl = 1'b0;
  logic [S-1:0]    slot_req = '0;
  logic [S*AW-1:0] slot_addr;
  logic [S*2-1:0]  slot_bank;
  logic            ack = 1'b0, rdy = 1'b0;
  logic [31:0]     rdata = '0;
  logic [S-1:0]    slot_ok, slot_err;
  logic [31:0]     slot_dout;
  logic            sdram_req, busy;
  logic [AW-1:0]   sdram_addr;
  logic [1:0]      sdram_bank;

  localparam logic [AW-1:0] A0 = 22'h000111, A1 = 22'h0ABCDE, A2 = 22'h012345, A3 = 22'h3FFFFF;

  jtframe_sdram_arb #(.SLOTS(S), .AW(AW), .TOUT_W(TW)) dut (
    .i_clk_rom(clk), .i_rst(rst), .i_downloading(dl),
    .i_slot_req(slot_req), .i_slot_addr(slot_addr), .i_slot_bank(slot_bank),
    .o_slot_ok(slot_ok), .o_slot_err(slot_err), .o_slot_dout(slot_dout),
    .o_sdram_req(sdram_req), .o_sdram_addr(sdram_addr), .o_sdram_bank(sdram_bank),
    .i_sdram_ack(ack), .i_data_rdy(rdy), .i_data_read(rdata), .o_busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: m_phase 0 = nothing outstanding, 1 = request posted, 2 = request accepted
  int            m_phase = 0, m_slot = 0, m_last = S - 1, m_age = 0, m_s;
  logic          m_req = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [1:0]    m_bank = '0;
  logic [S-1:0]  m_ok = '0, m_err = '0;
  logic [31:0]   m_dout = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0; m_slot = 0; m_last = S - 1; m_age = 0;
      m_req = 1'b0; m_addr = '0; m_bank = '0; m_ok = '0; m_err = '0; m_dout = '0;
    end else begin
      m_ok  = '0;
      m_err = '0;
      if (m_phase == 0) begin
        if (!dl && slot_req != '0) begin
          for (int k = 1; k <= S; k++) begin
            m_s = (m_last + k) % S;
            if (m_phase == 0 && slot_req[m_s]) begin
              m_slot  = m_s;
              m_phase = 1;
            end
          end
          m_req  = 1'b1;
          m_addr = slot_addr[m_slot*AW +: AW];
          m_bank = slot_bank[m_slot*2 +: 2];
          m_age  = 0;
        end
      end else begin
        m_age = m_age + 1;
        if (rdy && (m_phase == 2 || ack)) begin
          m_dout = rdata; m_ok[m_slot] = 1'b1; m_last = m_slot; m_phase = 0; m_req = 1'b0;
        end else if (m_phase == 1 && ack) begin
          m_phase = 2; m_req = 1'b0; m_age = 0;
        end else if (m_age == LIMIT) begin
          m_err[m_slot] = 1'b1; m_last = m_slot; m_phase = 0; m_req = 1'b0;
        end
      end
    end
  end

  int n_checks = 0, n_fail = 0;
  bit chk_en = 1'b0, auto_drop = 1'b0, auto_ctl = 1'b0;
  int ctl_wait = 0;
  logic [AW-1:0] ctl_addr = '0;
  int grant_log[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one cycle: compare against the model, then update requester/controller stimulus.
  task automatic cyc();
    @(negedge clk);
    if (chk_en) begin
      chk("model_req",  64'(sdram_req),  64'(m_req));
      chk("model_addr", 64'(sdram_addr), 64'(m_addr));
      chk("model_bank", 64'(sdram_bank), 64'(m_bank));
      chk("model_ok",   64'(slot_ok),    64'(m_ok));
      chk("model_err",  64'(slot_err),   64'(m_err));
      chk("model_dout", 64'(slot_dout),  64'(m_dout));
      chk("model_busy", 64'(busy),       64'(m_phase != 0));
    end
    ack = 1'b0;
    rdy = 1'b0;
    for (int s = 0; s < S; s++) if (slot_ok[s]) grant_log.push_back(s);
    if (auto_drop) slot_req = slot_req & ~(slot_ok | slot_err);
    if (auto_ctl) begin
      if (ctl_wait == 0 && sdram_req) begin
        ack = 1'b1; ctl_wait = 2; ctl_addr = sdram_addr;
      end else if (ctl_wait > 0) begin
        ctl_wait--;
        if (ctl_wait == 0) begin
          rdy = 1'b1; rdata = 32'hA5A50000 ^ {10'd0, ctl_addr};
        end
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; slot_req = '0; dl = 1'b0; auto_ctl = 1'b0; ctl_wait = 0;
    cyc(); cyc();
    rst = 1'b0;
  endtask

  task automatic wait_req(input string name);
    for (int i = 0; i < 40 && !sdram_req; i++) cyc();
    chk(name, 64'(sdram_req), 64'd1);
  endtask

  task automatic wait_ok(input string name, input logic [S-1:0] exp);
    for (int i = 0; i < 60; i++) begin
      cyc();
      if (slot_ok != '0) break;
    end
    chk(name, 64'(slot_ok), 64'(exp));
  endtask

  int exp_order[6] = '{0, 1, 2, 3, 0, 1};
  int cnt;

  initial begin
    slot_addr = {A3, A2, A1, A0};
    slot_bank = {2'd3, 2'd1, 2'd2, 2'd0};
    @(negedge clk); @(negedge clk);
    chk_en = 1'b1;
    chk("reset_req",  64'(sdram_req), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_dout", 64'(slot_dout), 64'd0);
    rst = 1'b0;

    // 1: single request from slot 2
    auto_drop = 1'b1;
    slot_req = 4'b0100;
    cyc();
    chk("t1_req",  64'(sdram_req), 64'd1);
    chk("t1_addr", 64'(sdram_addr), 64'h12345);
    chk("t1_bank", 64'(sdram_bank), 64'd1);
    cyc(); cyc();
    ack = 1'b1;
    cyc(); cyc(); cyc();
    rdy = 1'b1; rdata = 32'hDEADBEEF;
    cyc();
    chk("t1_ok",   64'(slot_ok), 64'b0100);
    chk("t1_dout", 64'(slot_dout), 64'hDEADBEEF);
    cyc();
    chk("t1_ok_one_cycle", 64'(slot_ok), 64'd0);
    chk("t1_idle_req", 64'(sdram_req), 64'd0);

    // 2: round-robin with all slots requesting
    do_reset();
    auto_drop = 1'b0; auto_ctl = 1'b1;
    grant_log.delete();
    slot_req = 4'b1111;
    for (int i = 0; i < 200 && grant_log.size() < 6; i++) cyc();
    slot_req = '0;
    for (int i = 0; i < 20 && (busy || ctl_wait != 0); i++) cyc();
    chk("t2_log_size", 64'(grant_log.size() >= 6), 64'd1);
    for (int i = 0; i < 6 && i < grant_log.size(); i++)
      chk($sformatf("t2_order%0d", i), 64'(grant_log[i]), 64'(exp_order[i]));
    for (int i = 1; i < grant_log.size(); i++)
      chk("t2_no_repeat", 64'(grant_log[i] != grant_log[i-1]), 64'd1);

    // 3: ack and data_rdy in the same cycle
    do_reset();
    auto_drop = 1'b1;
    slot_req = 4'b0001;
    wait_req("t3_req");
    ack = 1'b1; rdy = 1'b1; rdata = 32'h0BADF00D;
    cyc();
    chk("t3_ok",   64'(slot_ok), 64'b0001);
    chk("t3_req0", 64'(sdram_req), 64'd0);
    chk("t3_busy", 64'(busy), 64'd0);
    chk("t3_dout", 64'(slot_dout), 64'h0BADF00D);

    // 4: watchdog timeout on slot 1, then slot 2 served
    do_reset();
    auto_drop = 1'b1;
    slot_req = 4'b0010;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (slot_err != '0) break;
      if (sdram_req) cnt++;
    end
    chk("t4_err",     64'(slot_err), 64'b0010);
    chk("t4_ok0",     64'(slot_ok), 64'd0);
    chk("t4_req0",    64'(sdram_req), 64'd0);
    chk("t4_req_len", 64'(cnt), 64'(LIMIT));
    slot_req = 4'b0100; auto_ctl = 1'b1;
    wait_ok("t4_slot2_ok", 4'b0100);

    // 5: download gating, including downloading rising mid-transaction
    do_reset();
    auto_drop = 1'b1;
    dl = 1'b1; slot_req = 4'b0011;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("t5_gated", 64'(sdram_req), 64'd0);
    end
    dl = 1'b0;
    cyc();
    chk("t5_req",  64'(sdram_req), 64'd1);
    chk("t5_addr", 64'(sdram_addr), 64'(A0));
    dl = 1'b1; auto_ctl = 1'b1;
    wait_ok("t5_ok0", 4'b0001);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("t5_gated2", 64'(sdram_req), 64'd0);
    end
    dl = 1'b0;
    cyc();
    chk("t5_req1",  64'(sdram_req), 64'd1);
    chk("t5_addr1", 64'(sdram_addr), 64'(A1));
    wait_ok("t5_ok1", 4'b0010);
    auto_ctl = 1'b0; ctl_wait = 0;
    cyc();

    // 6: reset while waiting for data
    slot_req = 4'b0100;
    wait_req("t6_req");
    chk("t6_addr", 64'(sdram_addr), 64'(A2));
    ack = 1'b1;
    cyc();
    chk("t6_busy", 64'(busy), 64'd1);
    rst = 1'b1; slot_req = 4'b0101;
    cyc();
    chk("t6_rst_req",  64'(sdram_req), 64'd0);
    chk("t6_rst_addr", 64'(sdram_addr), 64'd0);
    chk("t6_rst_bank", 64'(sdram_bank), 64'd0);
    chk("t6_rst_dout", 64'(slot_dout), 64'd0);
    chk("t6_rst_busy", 64'(busy), 64'd0);
    rst = 1'b0; rdy = 1'b1; rdata = 32'hFFFFFFFF;
    cyc();
    chk("t6_no_ok",    64'(slot_ok), 64'd0);
    chk("t6_req",      64'(sdram_req), 64'd1);
    chk("t6_addr0",    64'(sdram_addr), 64'(A0));
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
